// File: rtl/demux_1xn_reg.sv
// demux_1xn_reg: registered 1-to-N demultiplexer with a one-entry holding
// register per output channel and valid/ready handshakes on both sides.
// The target channel is Sel (Mode=0) or an internal round-robin pointer (Mode=1).
//
// Ports:
//   Clk        system clock, rising edge
//   Reset      synchronous active-high reset
//   Mode       0 = explicit select via Sel, 1 = auto round-robin via Ptr
//   Sel        explicit target channel
//   E          input valid
//   In_Data    input word
//   In_Ready   input may be accepted this cycle (combinational)
//   Out_Data   channel k at bits [k*W +: W]
//   Out_Valid  channel k holds a word
//   Out_Ready  consumer k takes its word this cycle
//   Ptr        round-robin pointer
//   Err        one-cycle pulse after a discarded out-of-range word
//   Err_Count  saturating count of discarded words
//
// Optional feature macro: DEMUX_ERR_EN (enables Err / Err_Count; tied 0 otherwise).

module demux_1xn_reg #(
    parameter int unsigned N    = 4,
    parameter int unsigned W    = 8,
    parameter int unsigned SELW = 2
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Mode,
    input  logic [SELW-1:0] Sel,
    input  logic            E,
    input  logic [W-1:0]    In_Data,
    output logic            In_Ready,
    output logic [N*W-1:0]  Out_Data,
    output logic [N-1:0]    Out_Valid,
    input  logic [N-1:0]    Out_Ready,
    output logic [SELW-1:0] Ptr,
    output logic            Err,
    output logic [7:0]      Err_Count
);

    localparam int unsigned NM1 = N - 1;

    logic [SELW-1:0] tgt;
    logic            in_range;
    logic [N-1:0]    hit;
    logic [N-1:0]    load;
    logic            xfer;

    // Target decode; out-of-range targets (Sel >= N) are accepted and dropped
    always_comb begin
        tgt      = Mode ? Ptr : Sel;
        in_range = (tgt <= SELW'(NM1));
        hit      = '0;
        for (int k = 0; k < N; k++) begin
            hit[k] = in_range && (tgt == SELW'(k));
        end
        In_Ready = 1'b0;
        if (!Reset) begin
            In_Ready = !in_range || (|(hit & (~Out_Valid | Out_Ready)));
        end
        xfer = E && In_Ready;
        load = xfer ? hit : '0;
    end

    // Channel holding registers: a load wins over a simultaneous drain
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Out_Valid <= '0;
            Out_Data  <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (load[k]) begin
                    Out_Valid[k]         <= 1'b1;
                    Out_Data[k*W +: W]   <= In_Data;
                end else if (Out_Ready[k]) begin
                    Out_Valid[k]         <= 1'b0;
                end
            end
        end
    end

    // Round-robin pointer; explicit wrap so non-power-of-two N works
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Ptr <= '0;
        end else if (xfer && Mode) begin
            Ptr <= (Ptr == SELW'(NM1)) ? '0 : Ptr + SELW'(1);
        end
    end

`ifdef DEMUX_ERR_EN
    // Discard reporting: pulse plus saturating counter
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Err       <= 1'b0;
            Err_Count <= '0;
        end else begin
            Err <= xfer && !in_range;
            if (xfer && !in_range && (Err_Count != 8'hFF)) begin
                Err_Count <= Err_Count + 8'd1;
            end
        end
    end
`else
    assign Err       = 1'b0;
    assign Err_Count = 8'h00;
`endif

endmodule

// File: tb/tb_demux_1xn_reg.sv
// tb_demux_1xn_reg: directed self-checking bench for demux_1xn_reg.
// d4 is the default N=4 build; d3 is an N=3 build for out-of-range and wrap cases.

module tb_demux_1xn_reg;

    logic        clk = 1'b0;
    logic        reset;
    int          checks = 0;
    int          errors = 0;

    // N=4 instance signals
    logic        mode, e, in_ready;
    logic [1:0]  sel, ptr;
    logic [7:0]  in_data, err_count;
    logic [31:0] out_data;
    logic [3:0]  out_valid, out_ready;
    logic        err;

    // N=3 instance signals
    logic        mode3, e3, in_ready3;
    logic [1:0]  sel3, ptr3;
    logic [7:0]  in_data3, err_count3;
    logic [23:0] out_data3;
    logic [2:0]  out_valid3, out_ready3;
    logic        err3;

    always #5 clk = ~clk;

    demux_1xn_reg #(.N(4), .W(8), .SELW(2)) d4 (
        .Clk(clk), .Reset(reset), .Mode(mode), .Sel(sel), .E(e),
        .In_Data(in_data), .In_Ready(in_ready), .Out_Data(out_data),
        .Out_Valid(out_valid), .Out_Ready(out_ready), .Ptr(ptr),
        .Err(err), .Err_Count(err_count)
    );

    demux_1xn_reg #(.N(3), .W(8), .SELW(2)) d3 (
        .Clk(clk), .Reset(reset), .Mode(mode3), .Sel(sel3), .E(e3),
        .In_Data(in_data3), .In_Ready(in_ready3), .Out_Data(out_data3),
        .Out_Valid(out_valid3), .Out_Ready(out_ready3), .Ptr(ptr3),
        .Err(err3), .Err_Count(err_count3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; mode = 1'b0; sel = 2'd0; e = 1'b0; in_data = 8'h00; out_ready = 4'h0;
        mode3 = 1'b0; sel3 = 2'd0; e3 = 1'b0; in_data3 = 8'h00; out_ready3 = 3'h0;
        tick();
        e = 1'b1; out_ready = 4'hF;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        tick();
        checks++; if (out_valid !== 4'h0) begin errors++; $display("FAIL reset_valid: got %h expected 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", out_data); end
        checks++; if (ptr !== 2'd0) begin errors++; $display("FAIL reset_ptr: got %0d expected 0", ptr); end
        checks++; if (err !== 1'b0 || err_count !== 8'h00) begin errors++; $display("FAIL reset_err: got %b/%h expected 0/00", err, err_count); end
        // First explicit load after reset
        reset = 1'b0; e = 1'b1; sel = 2'd2; in_data = 8'hA5; out_ready = 4'h0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL first_in_ready: got %b expected 1", in_ready); end
        tick();
        e = 1'b0;
        checks++; if (out_valid !== 4'b0100) begin errors++; $display("FAIL first_valid: got %b expected 0100", out_valid); end
        checks++; if (out_data !== 32'h00A5_0000) begin errors++; $display("FAIL first_data: got %h expected 00a50000", out_data); end
        checks++; if (ptr !== 2'd0) begin errors++; $display("FAIL first_ptr: got %0d expected 0", ptr); end
    endtask

    task automatic test_stall();
        sel = 2'd1; in_data = 8'h11; e = 1'b1;
        tick();
        checks++; if (out_valid !== 4'b0110) begin errors++; $display("FAIL stall_pre_valid: got %b expected 0110", out_valid); end
        in_data = 8'h3C;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b expected 0", in_ready); end
        tick();
        checks++; if (out_data !== 32'h00A5_1100) begin errors++; $display("FAIL stall_hold: got %h expected 00a51100", out_data); end
        out_ready = 4'b0010;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release: got %b expected 1", in_ready); end
        tick();
        e = 1'b0; out_ready = 4'h0;
        checks++; if (out_valid !== 4'b0110) begin errors++; $display("FAIL drain_load_valid: got %b expected 0110", out_valid); end
        checks++; if (out_data !== 32'h00A5_3C00) begin errors++; $display("FAIL drain_load_data: got %h expected 00a53c00", out_data); end
        // Drain only: channel 2 empties, data kept
        out_ready = 4'b0100;
        tick();
        out_ready = 4'h0;
        checks++; if (out_valid !== 4'b0010) begin errors++; $display("FAIL drain_valid: got %b expected 0010", out_valid); end
        checks++; if (out_data !== 32'h00A5_3C00) begin errors++; $display("FAIL drain_data: got %h expected 00a53c00", out_data); end
    endtask

    task automatic test_round_robin();
        logic [1:0] c;
        mode = 1'b1; out_ready = 4'hF; e = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            c = 2'((i - 1) % 4);
            in_data = 8'(i);
            #1;
            checks++; if (ptr !== c) begin errors++; $display("FAIL rr_ptr_%0d: got %0d expected %0d", i, ptr, c); end
            tick();
            checks++; if (out_valid !== (4'b0001 << c)) begin errors++; $display("FAIL rr_valid_%0d: got %b expected ch %0d", i, out_valid, c); end
            checks++; if (out_data[c*8 +: 8] !== 8'(i)) begin errors++; $display("FAIL rr_data_%0d: got %h expected %h", i, out_data[c*8 +: 8], 8'(i)); end
        end
        e = 1'b0;
        checks++; if (ptr !== 2'd2) begin errors++; $display("FAIL rr_ptr_end: got %0d expected 2", ptr); end
        tick();
        checks++; if (out_valid !== 4'h0) begin errors++; $display("FAIL rr_drained: got %b expected 0000", out_valid); end
        out_ready = 4'h0;
    endtask

    task automatic test_out_of_range();
        sel3 = 2'd1; in_data3 = 8'h55; e3 = 1'b1;
        tick();
        sel3 = 2'd3; in_data3 = 8'hFF;
        #1;
        checks++; if (in_ready3 !== 1'b1) begin errors++; $display("FAIL oor_in_ready: got %b expected 1", in_ready3); end
        tick();
        e3 = 1'b0;
        checks++; if (out_valid3 !== 3'b010) begin errors++; $display("FAIL oor_valid: got %b expected 010", out_valid3); end
        checks++; if (out_data3 !== 24'h00_5500) begin errors++; $display("FAIL oor_data: got %h expected 005500", out_data3); end
        checks++; if (ptr3 !== 2'd0) begin errors++; $display("FAIL oor_ptr: got %0d expected 0", ptr3); end
`ifdef DEMUX_ERR_EN
        checks++; if (err3 !== 1'b1 || err_count3 !== 8'd1) begin errors++; $display("FAIL oor_err: got %b/%0d expected 1/1", err3, err_count3); end
        tick();
        checks++; if (err3 !== 1'b0) begin errors++; $display("FAIL oor_err_pulse: got %b expected 0", err3); end
`else
        checks++; if (err3 !== 1'b0 || err_count3 !== 8'd0) begin errors++; $display("FAIL oor_err_off: got %b/%0d expected 0/0", err3, err_count3); end
        tick();
`endif
        // Non-power-of-two wrap: 2 -> 0
        mode3 = 1'b1; out_ready3 = 3'b111; e3 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data3 = 8'(8'hB0 + i);
            tick();
        end
        e3 = 1'b0;
        checks++; if (ptr3 !== 2'd0) begin errors++; $display("FAIL wrap3_ptr: got %0d expected 0", ptr3); end
        checks++; if (out_valid3 !== 3'b100 || out_data3[23:16] !== 8'hB2) begin errors++; $display("FAIL wrap3_last: got %b/%h expected 100/b2", out_valid3, out_data3[23:16]); end
        // Long discard run for counter saturation
        mode3 = 1'b0; sel3 = 2'd3; e3 = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        e3 = 1'b0;
        tick();
`ifdef DEMUX_ERR_EN
        checks++; if (err_count3 !== 8'd255) begin errors++; $display("FAIL err_sat: got %0d expected 255", err_count3); end
`else
        checks++; if (err_count3 !== 8'd0) begin errors++; $display("FAIL err_off_count: got %0d expected 0", err_count3); end
`endif
        checks++; if (ptr3 !== 2'd0) begin errors++; $display("FAIL oor_run_ptr: got %0d expected 0", ptr3); end
        out_ready3 = 3'b000;
    endtask

    task automatic test_reset_mid();
        mode = 1'b0; out_ready = 4'h0; e = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i); in_data = 8'(8'h10 * (i + 1));
            tick();
        end
        checks++; if (out_valid !== 4'hF || out_data !== 32'h4030_2010) begin errors++; $display("FAIL full_load: got %b/%h expected 1111/40302010", out_valid, out_data); end
        reset = 1'b1; sel = 2'd0; out_ready = 4'hF;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_in_ready: got %b expected 0", in_ready); end
        tick();
        reset = 1'b0; e = 1'b0; out_ready = 4'h0;
        checks++; if (out_valid !== 4'h0 || out_data !== 32'h0) begin errors++; $display("FAIL mid_reset_state: got %b/%h expected 0000/0", out_valid, out_data); end
        checks++; if (ptr !== 2'd0) begin errors++; $display("FAIL mid_reset_ptr: got %0d expected 0", ptr); end
    endtask

    task automatic test_mode_switch();
        mode = 1'b1; out_ready = 4'hF; e = 1'b1;
        in_data = 8'hA1; tick();
        in_data = 8'hA2; tick();
        checks++; if (ptr !== 2'd2) begin errors++; $display("FAIL ms_ptr_pre: got %0d expected 2", ptr); end
        mode = 1'b0; sel = 2'd0; in_data = 8'h77;
        tick();
        checks++; if (out_valid !== 4'b0001 || out_data[7:0] !== 8'h77) begin errors++; $display("FAIL ms_explicit: got %b/%h expected 0001/77", out_valid, out_data[7:0]); end
        checks++; if (ptr !== 2'd2) begin errors++; $display("FAIL ms_ptr_hold: got %0d expected 2", ptr); end
        mode = 1'b1; in_data = 8'h88;
        tick();
        checks++; if (out_valid !== 4'b0100 || out_data[23:16] !== 8'h88) begin errors++; $display("FAIL ms_auto: got %b/%h expected 0100/88", out_valid, out_data[23:16]); end
        checks++; if (ptr !== 2'd3) begin errors++; $display("FAIL ms_ptr_adv: got %0d expected 3", ptr); end
        // Idle cycle: nothing changes
        e = 1'b0; out_ready = 4'h0;
        tick();
        checks++; if (out_valid !== 4'b0100 || ptr !== 2'd3) begin errors++; $display("FAIL idle: got %b/%0d expected 0100/3", out_valid, ptr); end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_round_robin();
        test_out_of_range();
        test_reset_mid();
        test_mode_switch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_1xn_reg.md
Name: demux_1xn_reg

Overview:
Registered, parametrised 1-to-N demultiplexer. Successor to the combinational 1x2 demux.
Routes a W-bit data word from one valid/ready input to one of N output channels. Each output channel has a one-entry holding register with its own valid/ready handshake.
Target channel is either selected explicitly by Sel or chosen by an internal round-robin pointer (auto mode).
Sits between a single producer and N independent consumers, for example per-display or per-peripheral command lanes.

Parameters:
N, 4, number of output channels; 2 <= N <= 2**SELW
W, 8, data word width in bits
SELW, 2, width of Sel and Ptr

Ports:
Clk  input  1  system clock; all state updates on rising edge
Reset  input  1  synchronous, active-high reset
Mode  input  1  0 = explicit select via Sel; 1 = auto round-robin via Ptr
Sel  input  SELW  target channel in Mode=0
E  input  1  input valid (enable)
In_Data  input  W  input word
In_Ready  output  1  input may be accepted this cycle (combinational)
Out_Data  output  N*W  channel k occupies bits [k*W +: W]
Out_Valid  output  N  channel k holds a word
Out_Ready  input  N  consumer k takes its word this cycle
Ptr  output  SELW  current auto-mode pointer
Err  output  1  one-cycle pulse on discarded out-of-range word (DEMUX_ERR_EN only; tied 0 otherwise)
Err_Count  output  8  saturating count of discarded words (DEMUX_ERR_EN only; tied 0 otherwise)

Behaviour:
- Reset, checked synchronously at the clock edge:
  - Out_Valid = 0, Out_Data = 0, Ptr = 0, Err = 0, Err_Count = 0.
  - Any held words are discarded.
  - While Reset = 1, In_Ready = 0, so no handshake completes during reset.
- Target: T = Mode ? Ptr : Sel.
- Range: T is in range if T < N. Ptr is always in range. Sel may be out of range when N < 2**SELW.
- In_Ready, when Reset = 0:
  - 1 if T is out of range;
  - otherwise ~Out_Valid[T] | Out_Ready[T].
- Transfer: a transfer occurs when E & In_Ready.
- Load, when a transfer occurs and T is in range:
  - next cycle, Out_Data[T] = In_Data and Out_Valid[T] = 1.
  - Latency from input to output is 1 cycle.
- Drain: when Out_Valid[k] & Out_Ready[k], Out_Valid[k] clears next cycle, unless channel k is loaded in the same cycle.
- Simultaneous drain and load on the same channel: Out_Valid stays 1 and Out_Data takes the new word. This gives full throughput of 1 word per cycle per channel.
- Channels are independent: any subset may drain in the same cycle, and at most one channel loads per cycle.
- Out_Data[k] holds its last value while Out_Valid[k] = 0. It is cleared only by reset.
- Ptr:
  - advances only on a transfer while Mode = 1.
  - Wraps N-1 -> 0 explicitly; this also applies for non-power-of-two N.
  - Held while Mode = 0.
- Mode switch:
  - takes effect in the same cycle (combinational T).
  - Ptr value is retained across switches.
- Out-of-range transfer (Mode = 0, Sel >= N):
  - the word is accepted and discarded;
  - no Out_Valid change; Ptr unaffected.
- E = 0: no state change except drains.
- Stall: if target channel is full and Out_Ready[T] = 0, In_Ready = 0 and the producer must hold E and In_Data.

Optional Feature:
Macro DEMUX_ERR_EN.
- Defined:
  - Err pulses high for exactly the cycle after each out-of-range transfer.
  - Err_Count increments on each such transfer and saturates at 255.
  - Both are cleared by Reset.
- Undefined:
  - Err and Err_Count are constant 0 and no counter logic is synthesised.
  - Out-of-range words are still silently discarded.

Test Plan:
1. Reset = 1 for 2 cycles, then Mode = 0, Sel = 2, E = 1, In_Data = 8'hA5 for 1 cycle, all Out_Ready = 0 -> next cycle Out_Valid = 4'b0100, Out_Data[23:16] = 8'hA5, others 0; Ptr = 0.
2. Channel 1 full, Out_Ready[1] = 0, Mode = 0, Sel = 1, E = 1, In_Data = 8'h3C -> In_Ready = 0 and channel 1 keeps its old word. Then raise Out_Ready[1] = 1 -> In_Ready = 1; next cycle Out_Valid[1] = 1 with 8'h3C (simultaneous drain and load).
3. Mode = 1, Out_Ready = 4'b1111, E = 1 for 6 cycles with words 1..6 -> words land on channels 0, 1, 2, 3, 0, 1; Ptr sequence 0, 1, 2, 3, 0, 1, 2 (wrap checked).
4. N = 3, SELW = 2, Mode = 0, Sel = 3, E = 1, In_Data = 8'hFF -> In_Ready = 1, Out_Valid unchanged. With DEMUX_ERR_EN: Err = 1 for one cycle, Err_Count = 1. After 300 such transfers, Err_Count = 255.
5. Load all 4 channels (Out_Ready = 0), then assert Reset for 1 cycle with E = 1 -> In_Ready = 0 during reset; afterwards Out_Valid = 0, Out_Data = 0, Ptr = 0.
6. Mode = 1, Ptr = 2, switch to Mode = 0 with Sel = 0 for 1 transfer, then back to Mode = 1 -> word goes to channel 0, Ptr stays 2, and the next auto transfer goes to channel 2.
